// File: rtl/mcu0_pkg.sv
// Shared mcu0 definitions: bus geometry, bus-bridge FSM states and the core opcode set.
// Used by the core and by the word-to-byte bus bridge.
package mcu0_pkg;

    localparam int ADDR_W = 12;
    localparam int BYTE_W = 8;
    localparam int DATA_W = 2 * BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_B2   = 3'd3,
        S_DONE = 3'd4
    } bridge_state_e;

    typedef enum logic [2:0] {
        LD  = 3'd0,
        ADD = 3'd1,
        JMP = 3'd2,
        ST  = 3'd3,
        CMP = 3'd4,
        JEQ = 3'd5
    } opcode_e;

    // Second byte of a big-endian word; wraps at the top of the byte space.
    function automatic logic [ADDR_W-1:0] next_byte_addr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/mcu0_bus_bridge.sv
// Splits 16-bit core word accesses into two big-endian byte cycles on the synchronous RAM.
// Optional MCU0_BUS_ALIGN_CHK_EN: odd word addresses are rejected with err instead of serviced.
module mcu0_bus_bridge
    import mcu0_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata
);

    bridge_state_e     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              busy_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [BYTE_W-1:0] mem_wdata_q;
    logic              misaligned_d;

`ifdef MCU0_BUS_ALIGN_CHK_EN
    logic              err_q;

    assign misaligned_d = addr[0];
    assign err          = err_q;
`else
    assign misaligned_d = 1'b0;
    assign err          = 1'b0;
`endif

    assign rdata     = rdata_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Outputs are registered for the state being entered, so every strobe is a flop
    // and nothing on req/addr reaches the RAM pins combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef MCU0_BUS_ALIGN_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        wdata_q <= wdata;
                        busy_q  <= 1'b1;
                        if (misaligned_d) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            if (!we) begin
                                rdata_q <= '0;
                            end
`ifdef MCU0_BUS_ALIGN_CHK_EN
                            err_q   <= 1'b1;
`endif
                        end else begin
                            state_q     <= S_B0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= we;
                            mem_addr_q  <= addr;
                            mem_wdata_q <= wdata[DATA_W-1:BYTE_W];
                        end
                    end
                end
                S_B0: begin
                    state_q     <= S_B1;
                    mem_addr_q  <= next_byte_addr(addr_q);
                    mem_wdata_q <= wdata_q[BYTE_W-1:0];
                end
                // The RAM returns the high byte now; the low byte arrives one cycle later in B2.
                S_B1: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                    end else begin
                        rdata_q[DATA_W-1:BYTE_W] <= mem_rdata;
                        state_q                  <= S_B2;
                    end
                end
                S_B2: begin
                    rdata_q[BYTE_W-1:0] <= mem_rdata;
                    state_q             <= S_DONE;
                    ready_q             <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
`ifdef MCU0_BUS_ALIGN_CHK_EN
                    err_q   <= 1'b0;
`endif
                end
                default: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
